// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with start/busy/done handshake and held result.
// Define ALU_MUL_EN to build the shift-add multiply on opcode 1000.
module alu_mc #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       O,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
);

    logic [WIDTH-1:0] res_c;
    logic             err_c;

    // Single-cycle opcode decode; unknown codes flag err
    always_comb begin
        res_c = '0;
        err_c = 1'b0;
        case (O)
            4'b0000: res_c = A & B;
            4'b0001: res_c = A | B;
            4'b0010: res_c = A + B;
            4'b0110: res_c = A - B;
            4'b0100: res_c = ~(A | B);
            4'b0111: res_c[0] = $signed(A) < $signed(B);
            4'b1011: res_c[0] = A < B;
            4'b0011: res_c = A ^ B;
            4'b0101: res_c = B >> A[SHW-1:0];
            4'b1101: res_c = B << A[SHW-1:0];
            default: err_c = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc_nxt;
    logic [SHW-1:0]   cnt;

    // Only the low half is kept, so bits shifted out of a_sh never matter
    assign acc_nxt = acc + (b_sh[0] ? a_sh : '0);

    // Control FSM: single-cycle ops finish in IDLE, mul walks WIDTH steps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            zero   <= 1'b1;
            err    <= 1'b0;
            acc    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (O == 4'b1000) begin
                            a_sh  <= A;
                            b_sh  <= B;
                            acc   <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= MUL;
                        end else begin
                            result <= res_c;
                            zero   <= (res_c == '0);
                            err    <= err_c;
                            done   <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    // Last step writes its sum straight to result
                    if (cnt == SHW'(WIDTH - 1)) begin
                        result <= acc_nxt;
                        zero   <= (acc_nxt == '0);
                        err    <= 1'b0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + SHW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign busy = 1'b0;

    // Every op is single-cycle: latch result on the start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done   <= 1'b0;
            result <= '0;
            zero   <= 1'b1;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                result <= res_c;
                zero   <= (res_c == '0);
                err    <= err_c;
                done   <= 1'b1;
            end
        end
    end
`endif

endmodule
